usb2_ep_in_filler: RTL and testbench

//  Upstream producer for the usb2 endpoint double buffer. Packs a byte stream

---
 rtl/usb2_ep_in_filler_pkg.sv | 23 ++
 rtl/usb2_ep_in_filler_idle_timer.sv | 32 +++
 rtl/usb2_ep_in_filler.sv | 119 +++++++++++
 tb/tb_usb2_ep_in_filler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb2_ep_in_filler_pkg.sv
// Shared types and helpers for the endpoint IN filler.
// Holds the filler state encoding and the byte-count width used for
// both the write address and the committed packet length.
package usb2_ep_in_filler_pkg;

    // 11 bits so that a full 1024-byte packet length is representable.
    localparam int CNT_W = 11;

    typedef enum logic [2:0] {
        ST_F_IDLE    = 3'd0,
        ST_F_FILL    = 3'd1,
        ST_F_COMMIT  = 3'd2,
        ST_F_RELEASE = 3'd3,
        ST_F_WAIT1   = 3'd4
    } filler_state_t;

    // Byte count after an optional accept in the current cycle.
    function automatic logic [CNT_W-1:0] bump_count(input logic [CNT_W-1:0] cnt,
                                                    input logic inc);
        return cnt + CNT_W'(inc);
    endfunction

endpackage

// File: rtl/usb2_ep_in_filler_idle_timer.sv
// Idle timer for the IN filler.
// Counts cycles in FILL without an accepted byte and flags when the
// configured idle limit has been reached. A TIMEOUT of 0 disables it.
module usb2_ep_in_filler_idle_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_fill,
    input  logic accept,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CW-1:0] idle_cnt;

    // Restart on every accepted byte or outside FILL, saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!in_fill || accept) begin
            idle_cnt <= '0;
        end else if (idle_cnt != LIMIT) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (idle_cnt == LIMIT);

endmodule

// File: rtl/usb2_ep_in_filler.sv
// Endpoint IN filler: packs a byte stream into the endpoint write port
// and commits each packet when it is full, on end-of-transfer, on flush
// or after an idle timeout. Runs entirely on the endpoint write clock.
module usb2_ep_in_filler
    import usb2_ep_in_filler_pkg::*;
#(
    parameter int MAX_PKT = 512,
    parameter int TIMEOUT = 1024,
    parameter int ZLP_EN  = 1
) (
    input  logic             phy_clk,
    input  logic             reset_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    input  logic             flush,
    output logic [CNT_W-1:0] buf_in_addr,
    output logic [7:0]       buf_in_data,
    output logic             buf_in_wren,
    input  logic             buf_in_ready,
    output logic             buf_in_commit,
    output logic [CNT_W-1:0] buf_in_commit_len,
    input  logic             buf_in_commit_ack,
    output logic             busy,
    output logic [15:0]      pkt_count
);

    localparam logic [CNT_W-1:0] PKT_LEN = CNT_W'(MAX_PKT);
    localparam logic             ZLP     = (ZLP_EN != 0);

    filler_state_t    state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             accept;
    logic             timeout_hit;
    logic             fill_done;

    // Stream handshake and status are pure decodes of the state register.
    assign s_ready    = (state == ST_F_FILL);
    assign busy       = (state != ST_F_IDLE);
    assign accept     = s_valid && s_ready;
    assign count_next = bump_count(count, accept);

    // A packet closes on the byte that fills it or carries s_last, on flush
    // (a flushed byte is still included), or on timeout with data pending.
    assign fill_done = (accept && ((count_next == PKT_LEN) || s_last))
                     || (flush && ((count_next != '0) || ZLP))
                     || (timeout_hit && (count != '0));

    usb2_ep_in_filler_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (phy_clk),
        .rst_n   (reset_n),
        .in_fill (s_ready),
        .accept  (accept),
        .expired (timeout_hit)
    );

    // Packet FSM: fill the endpoint half, commit it, then wait out the swap.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_F_IDLE;
            count             <= '0;
            buf_in_addr       <= '0;
            buf_in_data       <= '0;
            buf_in_wren       <= 1'b0;
            buf_in_commit     <= 1'b0;
            buf_in_commit_len <= '0;
            pkt_count         <= '0;
        end else begin
            buf_in_wren <= 1'b0;
            case (state)
                ST_F_IDLE: begin
                    count <= '0;
                    if (buf_in_ready) begin
                        state <= ST_F_FILL;
                    end
                end
                ST_F_FILL: begin
                    if (accept) begin
                        buf_in_addr <= count;
                        buf_in_data <= s_data;
                        buf_in_wren <= 1'b1;
                        count       <= count_next;
                    end
                    if (fill_done) begin
                        buf_in_commit_len <= count_next;
                        state             <= ST_F_COMMIT;
                    end
                end
                ST_F_COMMIT: begin
                    // Commit is raised the cycle after the final write so the
                    // endpoint always sees the last byte before the request.
                    if (!buf_in_commit) begin
                        buf_in_commit <= 1'b1;
                    end else if (buf_in_commit_ack) begin
                        buf_in_commit <= 1'b0;
                        pkt_count     <= pkt_count + 16'd1;
                        state         <= ST_F_RELEASE;
                    end
                end
                ST_F_RELEASE: begin
                    if (!buf_in_commit_ack) begin
                        state <= ST_F_WAIT1;
                    end
                end
                ST_F_WAIT1: begin
                    state <= ST_F_IDLE;
                end
                default: begin
                    state <= ST_F_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb2_ep_in_filler.sv
// Directed bench for the endpoint IN filler with a write/commit scoreboard.
module tb_usb2_ep_in_filler;

    localparam int MAX_PKT = 512;
    localparam int TIMEOUT = 16;
    localparam int GUARD   = 4000;

    logic        phy_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        flush = 1'b0;
    logic        buf_in_ready = 1'b0;
    logic        buf_in_commit_ack = 1'b0;
    logic        s_ready;
    logic [10:0] buf_in_addr;
    logic [7:0]  buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        busy;
    logic [15:0] pkt_count;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int len;
        int gap;
    } cm_t;

    wr_t wr_q[$];
    cm_t cm_q[$];
    wr_t wr_e;
    cm_t cm_e;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_wren_cyc = 0;
    int   ack_fall_cyc = 0;
    int   model_cnt = 0;
    int   exp_pkts = 0;
    int   cur_len = 0;
    int   ack_delay = 1;
    int   ack_width = 2;
    bit   rel_pending = 1'b0;
    bit   rel_check_en = 1'b0;
    logic prev_commit = 1'b0;
    logic prev_ack = 1'b0;

    usb2_ep_in_filler #(
        .MAX_PKT (MAX_PKT),
        .TIMEOUT (TIMEOUT),
        .ZLP_EN  (1)
    ) dut (
        .phy_clk           (phy_clk),
        .reset_n           (reset_n),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_last            (s_last),
        .flush             (flush),
        .buf_in_addr       (buf_in_addr),
        .buf_in_data       (buf_in_data),
        .buf_in_wren       (buf_in_wren),
        .buf_in_ready      (buf_in_ready),
        .buf_in_commit     (buf_in_commit),
        .buf_in_commit_len (buf_in_commit_len),
        .buf_in_commit_ack (buf_in_commit_ack),
        .busy              (busy),
        .pkt_count         (pkt_count)
    );

    // Free-running clock and cycle counter.
    always #5 phy_clk = ~phy_clk;

    always @(posedge phy_clk) cyc = cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelCommit(input int len, input int gap);
        cm_q.push_back('{len, gap});
        exp_pkts++;
        model_cnt = 0;
    endtask

    // Offer one byte (optionally with s_last or flush); returns at the
    // negedge after the byte was accepted.
    task automatic applyStimulus(input logic [7:0] b, input logic last, input logic fl);
        int guard = 0;
        s_data  = b;
        s_valid = 1'b1;
        s_last  = last;
        flush   = fl;
        while (s_ready !== 1'b1 && guard < GUARD) begin
            @(negedge phy_clk);
            guard++;
        end
        if (guard >= GUARD) checkOutput("accept_timeout", {31'd0, s_ready}, 1);
        wr_q.push_back('{11'(model_cnt), b});
        model_cnt++;
        if (model_cnt == MAX_PKT || last || fl) modelCommit(model_cnt, 1);
        @(negedge phy_clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic sendBurst(input int n, input logic last_on_final);
        for (int i = 0; i < n; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), last_on_final && (i == n - 1), 1'b0);
        end
    endtask

    // Wait until all expected commits are done and the filler is back in FILL.
    task automatic waitFill();
        int guard = 0;
        while (!(cm_q.size() == 0 && buf_in_commit === 1'b0 && s_ready === 1'b1) && guard < GUARD) begin
            @(negedge phy_clk);
            guard++;
        end
        if (guard >= GUARD)
            checkOutput("wait_fill_timeout",
                        {29'd0, cm_q.size() == 0, buf_in_commit === 1'b0, s_ready === 1'b1}, 7);
    endtask

    // Endpoint model: acknowledge each commit after a delay, for a set width.
    always begin
        @(posedge phy_clk);
        #1;
        if (reset_n === 1'b1 && buf_in_commit === 1'b1) begin
            repeat (ack_delay) begin
                @(posedge phy_clk);
                #1;
            end
            buf_in_commit_ack = 1'b1;
            repeat (ack_width) begin
                @(posedge phy_clk);
                #1;
            end
            buf_in_commit_ack = 1'b0;
            ack_fall_cyc = cyc;
            rel_pending  = 1'b1;
        end
    end

    // Scoreboard monitor: compares writes and commits against the queues.
    always @(negedge phy_clk) begin
        if (reset_n === 1'b1) begin
            if (buf_in_wren === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checkOutput("unexpected_wren", wr_q.size(), 1);
                end else begin
                    wr_e = wr_q.pop_front();
                    checkOutput("wr_addr", {21'd0, buf_in_addr}, {21'd0, wr_e.addr});
                    checkOutput("wr_data", {24'd0, buf_in_data}, {24'd0, wr_e.data});
                end
                last_wren_cyc = cyc;
            end
            if (buf_in_commit === 1'b1 && prev_commit !== 1'b1) begin
                if (cm_q.size() == 0) begin
                    checkOutput("unexpected_commit", cm_q.size(), 1);
                end else begin
                    cm_e = cm_q.pop_front();
                    cur_len = cm_e.len;
                    checkOutput("commit_len", {21'd0, buf_in_commit_len}, cm_e.len);
                    if (cm_e.gap >= 0) checkOutput("commit_gap", cyc - last_wren_cyc, cm_e.gap);
                end
            end else if (buf_in_commit === 1'b1) begin
                checkOutput("commit_len_stable", {21'd0, buf_in_commit_len}, cur_len);
            end
            if (prev_commit === 1'b1 && buf_in_commit === 1'b0)
                checkOutput("commit_held_until_ack", {31'd0, prev_ack}, 1);
            if (rel_pending && s_ready === 1'b1) begin
                if (rel_check_en) checkOutput("release_to_fill", cyc - ack_fall_cyc, 3);
                rel_pending = 1'b0;
            end
        end
        prev_commit = buf_in_commit;
        prev_ack    = buf_in_commit_ack;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        #12;
        checkOutput("rst_flags", {28'd0, s_ready, buf_in_wren, buf_in_commit, busy}, 0);
        checkOutput("rst_addr_data", {13'd0, buf_in_addr, buf_in_data}, 0);
        checkOutput("rst_len_cnt", {5'd0, buf_in_commit_len, pkt_count}, 0);
        @(negedge phy_clk);
        reset_n = 1'b1;

        // Endpoint not ready: back-pressure only, no writes.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        for (int i = 0; i < 50; i++) begin
            @(negedge phy_clk);
            checkOutput("ep_full_idle", {29'd0, s_ready, buf_in_wren, busy}, 0);
        end
        buf_in_ready = 1'b1;
        sendBurst(5, 1'b1);
        waitFill();
        checkOutput("pkt_after_resume", {16'd0, pkt_count}, exp_pkts);

        // 1024 back-to-back bytes, s_last on the 1024th (two full packets).
        sendBurst(1024, 1'b1);
        waitFill();
        checkOutput("pkt_after_1024", {16'd0, pkt_count}, exp_pkts);

        // 100 bytes ending with s_last.
        sendBurst(100, 1'b1);
        waitFill();
        checkOutput("pkt_after_100", {16'd0, pkt_count}, exp_pkts);

        // Ack widths 1 and 4, checking the release-to-fill spacing.
        rel_check_en = 1'b1;
        ack_delay = 0;
        ack_width = 1;
        sendBurst(3, 1'b1);
        waitFill();
        ack_delay = 2;
        ack_width = 4;
        sendBurst(3, 1'b1);
        waitFill();
        rel_check_en = 1'b0;
        ack_delay = 1;
        ack_width = 2;
        checkOutput("pkt_after_acks", {16'd0, pkt_count}, exp_pkts);

        // Idle timeout with a partial packet of 10 bytes.
        sendBurst(10, 1'b0);
        modelCommit(10, TIMEOUT + 1);
        waitFill();

        // Flush with nothing buffered gives a zero-length packet.
        flush = 1'b1;
        modelCommit(0, -1);
        @(negedge phy_clk);
        flush = 1'b0;
        waitFill();

        // Flush together with an accepted byte includes that byte.
        sendBurst(3, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b1);
        waitFill();
        checkOutput("pkt_after_flush", {16'd0, pkt_count}, exp_pkts);

        // Reset in the middle of a packet.
        sendBurst(37, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_flags", {28'd0, s_ready, buf_in_wren, buf_in_commit, busy}, 0);
        checkOutput("midrst_addr_data", {13'd0, buf_in_addr, buf_in_data}, 0);
        checkOutput("midrst_pkt", {16'd0, pkt_count}, 0);
        model_cnt = 0;
        exp_pkts  = 0;
        @(negedge phy_clk);
        @(negedge phy_clk);
        reset_n = 1'b1;
        waitFill();
        sendBurst(3, 1'b1);
        waitFill();
        checkOutput("pkt_after_reset", {16'd0, pkt_count}, exp_pkts);
        checkOutput("wr_queue_empty", wr_q.size(), 0);
        checkOutput("cm_queue_empty", cm_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
